// File: rtl/pwm_multi_duty_ctrl.sv
// Multi-channel PWM: button-stepped duty per channel, one shared prescaled period counter,
// duty applied at period boundaries. Define PWM_MULTI_DUTY_CTRL_DEBOUNCE_EN to debounce the buttons.
module pwm_multi_duty_ctrl #(
  parameter int WIDTH      = 8,
  parameter int NUM_CH     = 2,
  parameter int STEP       = 16,
  parameter int PRESCALE   = 1,
  parameter int RESET_DUTY = 128,
  parameter int DB_CYCLES  = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              increase_duty_in,
  input  logic              decrease_duty_in,
  input  logic [CH_W-1:0]   ch_sel,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start,
  output logic [WIDTH:0]    duty_rd
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [WIDTH+1:0] DUTY_MAX = {2'b01, {WIDTH{1'b0}}};
  localparam logic [WIDTH+1:0] STEP_X   = (WIDTH + 2)'(STEP);
  localparam logic [WIDTH:0]   RST_D    = (WIDTH + 1)'(RESET_DUTY);

  if (NUM_CH < 1 || NUM_CH > 8 || PRESCALE < 1 || STEP < 1 || STEP > (1 << WIDTH) ||
      RESET_DUTY < 0 || RESET_DUTY > (1 << WIDTH) || DB_CYCLES < 1) begin : g_bad_param
    $error("pwm_multi_duty_ctrl: parameter out of range");
  end

  // bit 0 = increase button, bit 1 = decrease button
  logic [1:0] w_btn_raw;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] w_btn_lvl;
  logic [1:0] r_btn_prev;
  logic [1:0] w_btn_pulse;
  logic       w_inc;
  logic       w_dec;
  logic       w_step_en;

  assign w_btn_raw = {decrease_duty_in, increase_duty_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_MULTI_DUTY_CTRL_DEBOUNCE_EN
  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DB_CYCLES - 1);

  logic [1:0]      r_db_lvl;
  logic [DB_W-1:0] r_db_cnt [2];

  // Down-counter reloads while the level agrees; the level flips when it expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_lvl <= '0;
      for (int b = 0; b < 2; b++) r_db_cnt[b] <= DB_LOAD;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] == r_db_lvl[b]) begin
          r_db_cnt[b] <= DB_LOAD;
        end else if (r_db_cnt[b] == '0) begin
          r_db_lvl[b] <= r_sync2[b];
          r_db_cnt[b] <= DB_LOAD;
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] - 1'b1;
        end
      end
    end
  end

  assign w_btn_lvl = r_db_lvl;
`else
  assign w_btn_lvl = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_btn_prev <= '0;
    else        r_btn_prev <= w_btn_lvl;
  end

  assign w_btn_pulse = w_btn_lvl & ~r_btn_prev;
  assign w_inc       = w_btn_pulse[0];
  assign w_dec       = w_btn_pulse[1];
  assign w_step_en   = w_inc ^ w_dec;

  logic [PS_W-1:0]  r_presc;
  logic [WIDTH-1:0] r_cnt;
  logic [PS_W-1:0]  w_presc_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_tick;
  logic             w_wrap;
  logic             r_period_start;

  assign w_tick      = (r_presc == PS_LAST);
  assign w_wrap      = w_tick && (r_cnt == '1);
  assign w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
  assign w_cnt_nxt   = w_tick ? r_cnt + 1'b1 : r_cnt;

  // period_start is registered from the next counter state so it stays low during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc        <= '0;
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_presc        <= w_presc_nxt;
      r_cnt          <= w_cnt_nxt;
      r_period_start <= (w_cnt_nxt == '0) && (w_presc_nxt == '0);
    end
  end

  function automatic logic [WIDTH:0] f_step(input logic [WIDTH:0] pend, input logic up);
    logic [WIDTH+1:0] ext;
    logic [WIDTH+1:0] res;
    ext = {1'b0, pend};
    if (up) res = ((ext + STEP_X) > DUTY_MAX) ? DUTY_MAX : ext + STEP_X;
    else    res = (ext < STEP_X) ? '0 : ext - STEP_X;
    return (WIDTH + 1)'(res);
  endfunction

  logic [WIDTH:0]    r_duty_pend [NUM_CH];
  logic [WIDTH:0]    r_duty_act  [NUM_CH];
  logic [NUM_CH-1:0] r_pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_duty_pend[i] <= RST_D;
        r_duty_act[i]  <= RST_D;
      end
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_step_en && (ch_sel == CH_W'(i))) r_duty_pend[i] <= f_step(r_duty_pend[i], w_inc);
        if (w_wrap) r_duty_act[i] <= r_duty_pend[i];
        r_pwm[i] <= ({1'b0, r_cnt} < r_duty_act[i]);
      end
    end
  end

  always_comb begin
    duty_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) duty_rd = r_duty_pend[i];
    end
  end

  assign pwm_out      = r_pwm;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_multi_duty_ctrl.sv
// Directed bench for pwm_multi_duty_ctrl: a 2-channel instance plus a 3-channel instance for
// out-of-range channel selects. Debounce scenario runs when PWM_MULTI_DUTY_CTRL_DEBOUNCE_EN is defined.
module tb_pwm_multi_duty_ctrl;

`ifdef PWM_MULTI_DUTY_CTRL_DEBOUNCE_EN
  localparam int DB_LAT = 4;
`else
  localparam int DB_LAT = 0;
`endif
  localparam int PH = 8;

  logic       clk;
  logic       rst_n;
  logic       inc_btn;
  logic       dec_btn;
  logic       only3;
  logic       sel;
  logic [1:0] sel3;
  logic [1:0] pwm_out;
  logic       period_start;
  logic [8:0] duty_rd;
  logic [2:0] pwm3;
  logic       ps3;
  logic [8:0] duty_rd3;

  int n_checks;
  int n_fail;
  int win_h0;
  int win_h1;
  int win_ps;

  // expected-behaviour model state
  logic [7:0] m_cnt;
  logic [8:0] m_pend [3];
  logic [8:0] m_act  [3];
  logic [2:0] exp_pwm;
  logic       exp_ps;

  pwm_multi_duty_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .increase_duty_in (inc_btn & ~only3),
    .decrease_duty_in (dec_btn & ~only3),
    .ch_sel           (sel),
    .pwm_out          (pwm_out),
    .period_start     (period_start),
    .duty_rd          (duty_rd)
  );

  pwm_multi_duty_ctrl #(.NUM_CH(3)) dut3 (
    .clk              (clk),
    .rst_n            (rst_n),
    .increase_duty_in (inc_btn),
    .decrease_duty_in (dec_btn),
    .ch_sel           (sel3),
    .pwm_out          (pwm3),
    .period_start     (ps3),
    .duty_rd          (duty_rd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= 8'd0;
      exp_pwm <= 3'b000;
      exp_ps  <= 1'b0;
      for (int i = 0; i < 3; i++) m_act[i] <= 9'd128;
    end else begin
      m_cnt  <= m_cnt + 8'd1;
      exp_ps <= (m_cnt == 8'd255);
      for (int i = 0; i < 3; i++) exp_pwm[i] <= ({1'b0, m_cnt} < m_act[i]);
      if (m_cnt == 8'd255) for (int i = 0; i < 3; i++) m_act[i] <= m_pend[i];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic s);
    sel  = s;
    sel3 = {1'b0, s};
  endtask

  task automatic wait_cnt(input logic [7:0] tgt);
    int t;
    t = 0;
    while (m_cnt !== tgt && t < 600) begin
      tick(1);
      t++;
    end
  endtask

  // Compare every output against the model for n cycles and record per-window high counts.
  task automatic run_window(input int n, input string name);
    int err;
    err = 0; win_h0 = 0; win_h1 = 0; win_ps = 0;
    for (int k = 0; k < n; k++) begin
      tick(1);
      if (pwm_out !== exp_pwm[1:0] || period_start !== exp_ps || pwm3 !== exp_pwm || ps3 !== exp_ps) err++;
      win_h0 += int'(pwm_out[0]);
      win_h1 += int'(pwm_out[1]);
      win_ps += int'(period_start);
    end
    n_checks++;
    if (err != 0) begin
      n_fail++;
      $display("FAIL %s: %0d of %0d cycles differ from expected waveform (last pwm=%b exp=%b)",
               name, err, n, pwm_out, exp_pwm[1:0]);
    end
  endtask

  task automatic to_period_start(input string name);
    run_window((256 - int'(m_cnt)) % 256, name);
  endtask

  task automatic press(input logic up, input logic dn, input int hold, input int ch,
                       input logic [8:0] pre, input logic [8:0] post, input string name);
    inc_btn = up;
    dec_btn = dn;
    tick(2 + DB_LAT);
    n_checks++;
    if (duty_rd !== pre) begin
      n_fail++;
      $display("FAIL %s_early: duty_rd=%0d expected %0d", name, duty_rd, pre);
    end
    tick(1);
    if (ch >= 0) m_pend[ch] = post;
    n_checks++;
    if (duty_rd !== post) begin
      n_fail++;
      $display("FAIL %s_step: duty_rd=%0d expected %0d", name, duty_rd, post);
    end
    tick(hold - 3 - DB_LAT);
    inc_btn = 1'b0;
    dec_btn = 1'b0;
    tick(4 + DB_LAT);
    n_checks++;
    if (duty_rd !== post) begin
      n_fail++;
      $display("FAIL %s_settled: duty_rd=%0d expected %0d", name, duty_rd, post);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(5);
    n_checks++;
    if (pwm_out !== 2'b00 || pwm3 !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_pwm: pwm_out=%b pwm3=%b expected 0", pwm_out, pwm3);
    end
    n_checks++;
    if (period_start !== 1'b0 || ps3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_period_start: %b/%b expected 0", period_start, ps3);
    end
    n_checks++;
    if (duty_rd !== 9'd128 || duty_rd3 !== 9'd128) begin
      n_fail++;
      $display("FAIL reset_duty_ch0: duty_rd=%0d duty_rd3=%0d expected 128", duty_rd, duty_rd3);
    end
    set_sel(1'b1);
    #1;
    n_checks++;
    if (duty_rd !== 9'd128) begin
      n_fail++;
      $display("FAIL reset_duty_ch1: duty_rd=%0d expected 128", duty_rd);
    end
    set_sel(1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_steady();
    for (int p = 0; p < 2; p++) begin
      run_window(256, "steady_wave");
      n_checks++;
      if (win_h0 !== 128 || win_h1 !== 128) begin
        n_fail++;
        $display("FAIL steady_high: ch0=%0d ch1=%0d expected 128/128", win_h0, win_h1);
      end
      n_checks++;
      if (win_ps !== 1) begin
        n_fail++;
        $display("FAIL steady_period_start: %0d pulses expected 1", win_ps);
      end
    end
  endtask

  task automatic test_increase();
    set_sel(1'b0);
    wait_cnt(8'd50);
    press(1'b1, 1'b0, PH, 0, 9'd128, 9'd144, "inc_ch0");
    to_period_start("inc_current_period");
    run_window(256, "inc_next_period");
    n_checks++;
    if (win_h0 !== 144) begin
      n_fail++;
      $display("FAIL inc_ch0_high: %0d expected 144", win_h0);
    end
    n_checks++;
    if (win_h1 !== 128) begin
      n_fail++;
      $display("FAIL inc_ch1_untouched: %0d expected 128", win_h1);
    end
  endtask

  task automatic test_saturation();
    int e_pre;
    int e_post;
    set_sel(1'b1);
    for (int k = 1; k <= 9; k++) begin
      e_pre  = (128 + 16 * (k - 1) > 256) ? 256 : 128 + 16 * (k - 1);
      e_post = (128 + 16 * k > 256) ? 256 : 128 + 16 * k;
      press(1'b1, 1'b0, PH, 1, 9'(e_pre), 9'(e_post), "sat_inc");
    end
    to_period_start("sat_hi_lead");
    run_window(256, "sat_hi_period");
    n_checks++;
    if (win_h1 !== 256) begin
      n_fail++;
      $display("FAIL sat_full_high: ch1 high %0d expected 256", win_h1);
    end
    for (int k = 1; k <= 17; k++) begin
      e_pre  = (256 - 16 * (k - 1) < 0) ? 0 : 256 - 16 * (k - 1);
      e_post = (256 - 16 * k < 0) ? 0 : 256 - 16 * k;
      press(1'b0, 1'b1, PH, 1, 9'(e_pre), 9'(e_post), "sat_dec");
    end
    to_period_start("sat_lo_lead");
    run_window(256, "sat_lo_period");
    n_checks++;
    if (win_h1 !== 0 || win_h0 !== 144) begin
      n_fail++;
      $display("FAIL sat_full_low: ch1 high %0d expected 0, ch0 high %0d expected 144", win_h1, win_h0);
    end
  endtask

  task automatic test_simultaneous();
    set_sel(1'b0);
    press(1'b1, 1'b1, PH, 0, 9'd144, 9'd144, "both_ch0");
    set_sel(1'b1);
    press(1'b1, 1'b1, PH, 1, 9'd0, 9'd0, "both_ch1");
  endtask

  task automatic test_out_of_range();
    sel   = 1'b0;
    sel3  = 2'd3;
    only3 = 1'b1;
    #1;
    n_checks++;
    if (duty_rd3 !== 9'd0) begin
      n_fail++;
      $display("FAIL oor_readback: duty_rd3=%0d expected 0", duty_rd3);
    end
    press(1'b1, 1'b0, PH, -1, 9'd144, 9'd144, "oor_main");
    n_checks++;
    if (duty_rd3 !== 9'd0) begin
      n_fail++;
      $display("FAIL oor_after_press: duty_rd3=%0d expected 0", duty_rd3);
    end
    sel3 = 2'd0;
    #1;
    n_checks++;
    if (duty_rd3 !== 9'd144) begin
      n_fail++;
      $display("FAIL oor_ch0: duty_rd3=%0d expected 144", duty_rd3);
    end
    sel3 = 2'd1;
    #1;
    n_checks++;
    if (duty_rd3 !== 9'd0) begin
      n_fail++;
      $display("FAIL oor_ch1: duty_rd3=%0d expected 0", duty_rd3);
    end
    sel3 = 2'd2;
    #1;
    n_checks++;
    if (duty_rd3 !== 9'd128) begin
      n_fail++;
      $display("FAIL oor_ch2: duty_rd3=%0d expected 128", duty_rd3);
    end
    only3 = 1'b0;
    set_sel(1'b0);
    run_window(300, "oor_wave");
  endtask

  task automatic test_held();
    set_sel(1'b0);
    press(1'b1, 1'b0, 1000, 0, 9'd144, 9'd160, "held_inc");
    run_window(300, "held_wave");
  endtask

  task automatic test_mid_reset();
    wait_cnt(8'd77);
    n_checks++;
    if (pwm_out !== 2'b01) begin
      n_fail++;
      $display("FAIL pre_reset_pwm: pwm_out=%b expected 01", pwm_out);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) m_pend[i] = 9'd128;
    #1;
    n_checks++;
    if (pwm_out !== 2'b00 || pwm3 !== 3'b000 || period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_out: pwm_out=%b pwm3=%b ps=%b expected all 0", pwm_out, pwm3, period_start);
    end
    n_checks++;
    if (duty_rd !== 9'd128) begin
      n_fail++;
      $display("FAIL async_reset_duty: duty_rd=%0d expected 128", duty_rd);
    end
    tick(3);
    rst_n = 1'b1;
    run_window(256, "post_reset_wave");
    n_checks++;
    if (win_h0 !== 128 || win_h1 !== 128 || win_ps !== 1) begin
      n_fail++;
      $display("FAIL post_reset_period: ch0=%0d ch1=%0d ps=%0d expected 128/128/1", win_h0, win_h1, win_ps);
    end
    set_sel(1'b1);
    #1;
    n_checks++;
    if (duty_rd !== 9'd128) begin
      n_fail++;
      $display("FAIL post_reset_ch1: duty_rd=%0d expected 128", duty_rd);
    end
    set_sel(1'b0);
  endtask

`ifdef PWM_MULTI_DUTY_CTRL_DEBOUNCE_EN
  task automatic test_debounce();
    set_sel(1'b0);
    for (int g = 0; g < 4; g++) begin
      inc_btn = 1'b1;
      tick(2);
      inc_btn = 1'b0;
      tick(2);
    end
    tick(10);
    n_checks++;
    if (duty_rd !== 9'd128) begin
      n_fail++;
      $display("FAIL db_glitch: duty_rd=%0d expected 128", duty_rd);
    end
    press(1'b1, 1'b0, 10, 0, 9'd128, 9'd144, "db_press");
    run_window(300, "db_wave");
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    inc_btn  = 1'b0;
    dec_btn  = 1'b0;
    only3    = 1'b0;
    sel      = 1'b0;
    sel3     = 2'd0;
    for (int i = 0; i < 3; i++) m_pend[i] = 9'd128;
    test_reset();
    test_steady();
    test_increase();
    test_saturation();
    test_simultaneous();
    test_out_of_range();
    test_held();
    test_mid_reset();
`ifdef PWM_MULTI_DUTY_CTRL_DEBOUNCE_EN
    test_debounce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
